// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Brief    : Serial bit-pattern transmitter. Shifts a latched parallel
//            pattern out MSB first on x, repeated repeat_n times with gap
//            idle cycles between repetitions, then pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    output logic             x,
    output logic             sof,
    output logic             busy,
    output logic             done,
    output logic [3:0]       state_out
);

    localparam int c_IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_MSB = c_IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Transaction parameters captured on the accepted start
    logic [PAT_W-1:0]   r_pat;
    logic [PAT_W-1:0]   w_pat_nxt;
    logic [GAP_W-1:0]   r_gap_len;
    logic [GAP_W-1:0]   w_gap_len_nxt;

    // Working counters: repetitions still owed (including the current one),
    // index of the bit currently on x, and gap cycles still owed (including
    // the current one)
    logic [CNT_W-1:0]   r_reps;
    logic [CNT_W-1:0]   w_reps_nxt;
    logic [c_IDX_W-1:0] r_bit_idx;
    logic [c_IDX_W-1:0] w_bit_idx_nxt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_cnt_nxt;

    // Output registers, loaded with the values belonging to the next state
    logic               r_x;
    logic               r_sof;
    logic               r_busy;
    logic               r_done;
    logic               w_x;
    logic               w_sof;
    logic               w_busy;
    logic               w_done;

    logic [c_IDX_W-1:0] w_idx_dec;

    assign w_idx_dec = r_bit_idx - c_IDX_W'(1);

    // Next-state and next-output decode; outputs are precomputed here so they
    // appear on the same edge the state changes
    always_comb begin
        w_state_nxt   = r_state;
        w_pat_nxt     = r_pat;
        w_gap_len_nxt = r_gap_len;
        w_reps_nxt    = r_reps;
        w_bit_idx_nxt = r_bit_idx;
        w_gap_cnt_nxt = r_gap_cnt;
        w_x           = 1'b0;
        w_sof         = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;

        if (abort) begin
            // Abort wins over everything, including a same-cycle start;
            // drop straight back to idle with no done pulse
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_pat_nxt     = pattern;
                        w_gap_len_nxt = gap;
                        w_reps_nxt    = repeat_n;
                        if (repeat_n == '0) begin
                            // Nothing to send: report completion immediately
                            w_state_nxt = S_DONE;
                            w_done      = 1'b1;
                        end else begin
                            w_state_nxt   = S_SEND;
                            w_bit_idx_nxt = c_IDX_MSB;
                            w_x           = pattern[PAT_W-1];
                            w_sof         = 1'b1;
                            w_busy        = 1'b1;
                        end
                    end
                end

                S_SEND: begin
                    w_busy = 1'b1;
                    if (r_bit_idx != '0) begin
                        w_bit_idx_nxt = w_idx_dec;
                        w_x           = r_pat[w_idx_dec];
                    end else begin
                        // Last bit of this repetition is on x now
                        w_reps_nxt = r_reps - CNT_W'(1);
                        if (r_reps == CNT_W'(1)) begin
                            w_state_nxt = S_DONE;
                            w_busy      = 1'b0;
                            w_done      = 1'b1;
                        end else if (r_gap_len == '0) begin
                            // Back-to-back repetition
                            w_bit_idx_nxt = c_IDX_MSB;
                            w_x           = r_pat[PAT_W-1];
                            w_sof         = 1'b1;
                        end else begin
                            w_state_nxt   = S_GAP;
                            w_gap_cnt_nxt = r_gap_len;
                        end
                    end
                end

                S_GAP: begin
                    w_busy = 1'b1;
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        w_state_nxt   = S_SEND;
                        w_bit_idx_nxt = c_IDX_MSB;
                        w_x           = r_pat[PAT_W-1];
                        w_sof         = 1'b1;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                    end
                end

                S_DONE: begin
                    // done was already presented for this one cycle
                    w_state_nxt = S_IDLE;
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, counters, latched parameters and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_gap_len <= '0;
            r_reps    <= '0;
            r_bit_idx <= '0;
            r_gap_cnt <= '0;
            r_x       <= 1'b0;
            r_sof     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pat     <= w_pat_nxt;
            r_gap_len <= w_gap_len_nxt;
            r_reps    <= w_reps_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_x       <= w_x;
            r_sof     <= w_sof;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign x         = r_x;
    assign sof       = r_sof;
    assign busy      = r_busy;
    assign done      = r_done;
    assign state_out = {2'b00, r_state};

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_gen
// Brief    : Self-checking bench for seq_pattern_gen. A queue-based model
//            expands each accepted request into its expected per-cycle
//            output trace; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] pattern = 4'd0;
    logic [3:0] repeat_n = 4'd0;
    logic [3:0] gap = 4'd0;
    logic       x;
    logic       sof;
    logic       busy;
    logic       done;
    logic [3:0] state_out;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    seq_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .repeat_n  (repeat_n),
        .gap       (gap),
        .x         (x),
        .sof       (sof),
        .busy      (busy),
        .done      (done),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Entry layout: {x, sof, busy, done, state[1:0]}
    logic [5:0] q[$];
    logic [5:0] e = 6'd0;

    function automatic void expand(input logic [3:0] pat, input int rn, input int gp);
        for (int r = 0; r < rn; r++) begin
            for (int b = 3; b >= 0; b--)
                q.push_back({pat[b], (b == 3), 1'b1, 1'b0, 2'd1});
            if (r < rn - 1)
                for (int g = 0; g < gp; g++)
                    q.push_back(6'b001010);
        end
        q.push_back(6'b000111);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            e <= 6'd0;
        end else if (abort) begin
            q.delete();
            e <= 6'd0;
        end else if (q.size() > 0) begin
            e <= q.pop_front();
        end else if (start && e[1:0] == 2'd0) begin
            expand(pattern, int'(repeat_n), int'(gap));
            e <= q.pop_front();
        end else begin
            e <= 6'd0;
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("cycle_trace", {24'd0, x, sof, busy, done, state_out},
                  {24'd0, e[5:2], 2'b00, e[1:0]});
    end

    // ---------------- stimulus helpers ----------------
    task automatic launch(input logic [3:0] pat, input logic [3:0] rn, input logic [3:0] gp);
        @(negedge clk);
        pattern  = pat;
        repeat_n = rn;
        gap      = gp;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic capture(input int maxc, output logic [511:0] xs, output logic [511:0] sofs,
                           output int nbusy, output int ndone);
        bit fin;
        fin = 1'b0;
        xs = '0; sofs = '0; nbusy = 0; ndone = 0;
        for (int i = 0; i < maxc && !fin; i++) begin
            if (i > 0) @(negedge clk);
            if (busy) begin
                xs   = {xs[510:0], x};
                sofs = {sofs[510:0], sof};
                nbusy++;
            end
            if (done) begin
                ndone++;
                fin = 1'b1;
            end
        end
        check("capture_reached_done", {31'd0, fin}, 32'd1);
    endtask

    logic [511:0] xs, sofs;
    int nb, nd, seen;

    initial begin
        // 1: reset and idle
        #50 reset = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_x", {31'd0, x}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_state", {28'd0, state_out}, 32'd0);

        // 2: 1011 x2, gap 1
        launch(4'b1011, 4'd2, 4'd1);
        capture(50, xs, sofs, nb, nd);
        check("t2_bits", xs[31:0], 32'b101101011);
        check("t2_sof", sofs[31:0], 32'b100001000);
        check("t2_busy", nb, 9);
        check("t2_done", nd, 1);

        // 3: 1001 x3, back to back
        launch(4'b1001, 4'd3, 4'd0);
        capture(50, xs, sofs, nb, nd);
        check("t3_bits", xs[31:0], 32'b100110011001);
        check("t3_sof", sofs[31:0], 32'b100010001000);
        check("t3_busy", nb, 12);
        check("t3_done", nd, 1);

        // 4: zero repetitions
        launch(4'b1010, 4'd0, 4'd3);
        check("t4_state_done", {28'd0, state_out}, 32'd3);
        capture(5, xs, sofs, nb, nd);
        check("t4_busy", nb, 0);
        check("t4_done", nd, 1);
        @(negedge clk);
        check("t4_back_idle", {28'd0, state_out}, 32'd0);

        // 5a: disturb inputs mid-SEND
        launch(4'b1100, 4'd2, 4'd2);
        fork
            capture(50, xs, sofs, nb, nd);
            begin
                @(negedge clk);
                @(negedge clk);
                pattern = 4'b0011; repeat_n = 4'd7; gap = 4'd0; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check("t5_bits", xs[31:0], 32'b1100001100);
        check("t5_busy", nb, 10);
        check("t5_done", nd, 1);

        // 5b: abort during GAP
        launch(4'b1010, 4'd3, 4'd3);
        for (int i = 0; i < 20 && state_out != 4'd2; i++) @(negedge clk);
        check("t5_reach_gap", {28'd0, state_out}, 32'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_state", {28'd0, state_out}, 32'd0);
        check("t5_abort_busy", {31'd0, busy}, 32'd0);
        check("t5_abort_x", {31'd0, x}, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("t5_no_done", seen, 0);

        // abort and start together in IDLE
        abort = 1'b1; start = 1'b1; pattern = 4'b1111; repeat_n = 4'd1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("prio_busy", {31'd0, busy}, 32'd0);
        check("prio_state", {28'd0, state_out}, 32'd0);

        // 6: async reset mid-SEND
        launch(4'b1111, 4'd2, 4'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_x", {31'd0, x}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_state", {28'd0, state_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        launch(4'b1000, 4'd1, 4'd0);
        capture(20, xs, sofs, nb, nd);
        check("t6_bits", xs[31:0], 32'b1000);
        check("t6_sof", sofs[31:0], 32'b1000);
        check("t6_busy", nb, 4);

        // Maximum counts: 15*4 + 14*15 busy cycles
        launch(4'b0110, 4'd15, 4'd15);
        capture(400, xs, sofs, nb, nd);
        check("max_busy", nb, 270);
        check("max_done", nd, 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
